// File: rtl/rgb_to_yuv_decimation.sv
// Streams an interleaved RGB frame from SRAM, converts to YUV (Q16 fixed point) and writes
// Y plus 2:1 horizontally decimated U/V planes back. Build macro: CSD_CHROMA_FILTER_EN.
module rgb_to_yuv_decimation #(
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240,
    parameter int unsigned Y_BASE   = 0,
    parameter int unsigned U_BASE   = 38400,
    parameter int unsigned V_BASE   = 57600,
    parameter int unsigned RGB_BASE = 146944
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CSD_en,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address_o,
    output logic [15:0] SRAM_write_data_o,
    output logic        SRAM_we_n_o,
    output logic        done,
    output logic [6:0]  CSD_x,
    output logic [7:0]  CSD_y
);

    localparam logic [6:0]  LAST_X     = 7'(WIDTH / 4 - 1);
    localparam logic [7:0]  LAST_Y     = 8'(HEIGHT - 1);
    localparam logic [17:0] Y_BASE_A   = 18'(Y_BASE);
    localparam logic [17:0] U_BASE_A   = 18'(U_BASE);
    localparam logic [17:0] V_BASE_A   = 18'(V_BASE);
    localparam logic [17:0] RGB_BASE_A = 18'(RGB_BASE);

    typedef enum logic [2:0] {StIdle, StLeadIn, StRun, StLeadOut, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [6:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        done_q, done_d;
    logic [17:0] rgb_ptr_q, rgb_ptr_d;
    logic [17:0] y_ptr_q, y_ptr_d;
    logic [17:0] u_ptr_q, u_ptr_d;
    logic [17:0] v_ptr_q, v_ptr_d;
    logic [3:0]  tag_a_q, tag_b_q;
    logic [15:0] w_q [6];
    logic [15:0] y01_q, y23_q, u_q, v_q;
    logic [15:0] y01_d, y23_d, u_d, v_d;
    logic        rd_issue;
    logic        conv;
    logic        last_x;
    logic [7:0]  r [4];
    logic [7:0]  g [4];
    logic [7:0]  b [4];

    function automatic logic signed [31:0] sx(input logic [7:0] c);
        return $signed({24'd0, c});
    endfunction

    function automatic logic [7:0] clip8(input logic signed [31:0] v);
        if (v < 32'sd0) return 8'd0;
        if (v > 32'sd255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [7:0] y_of(input logic [7:0] cr, input logic [7:0] cg,
                                        input logic [7:0] cb);
        return clip8((32'sd16843 * sx(cr) + 32'sd33030 * sx(cg) + 32'sd6423 * sx(cb)
                      + 32'sd1081344) >>> 16);
    endfunction

    function automatic logic [7:0] u_of(input logic [7:0] cr, input logic [7:0] cg,
                                        input logic [7:0] cb);
        return clip8((32'sd28770 * sx(cb) - 32'sd9699 * sx(cr) - 32'sd19071 * sx(cg)
                      + 32'sd8421376) >>> 16);
    endfunction

    function automatic logic [7:0] v_of(input logic [7:0] cr, input logic [7:0] cg,
                                        input logic [7:0] cb);
        return clip8((32'sd28770 * sx(cr) - 32'sd24117 * sx(cg) - 32'sd4653 * sx(cb)
                      + 32'sd8421376) >>> 16);
    endfunction

`ifdef CSD_CHROMA_FILTER_EN
    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, c} + 9'd1;
        return s[8:1];
    endfunction
`endif

    assign last_x = (x_q == LAST_X);
    assign done   = done_q;
    assign CSD_x  = x_q;
    assign CSD_y  = y_q;

    // Unpack the six buffered words into four pixels; pixel 2k sits in the high byte first.
    always_comb begin
        r[0] = w_q[0][15:8]; g[0] = w_q[0][7:0];  b[0] = w_q[1][15:8];
        r[1] = w_q[1][7:0];  g[1] = w_q[2][15:8]; b[1] = w_q[2][7:0];
        r[2] = w_q[3][15:8]; g[2] = w_q[3][7:0];  b[2] = w_q[4][15:8];
        r[3] = w_q[4][7:0];  g[3] = w_q[5][15:8]; b[3] = w_q[5][7:0];
        y01_d = {y_of(r[0], g[0], b[0]), y_of(r[1], g[1], b[1])};
        y23_d = {y_of(r[2], g[2], b[2]), y_of(r[3], g[3], b[3])};
`ifdef CSD_CHROMA_FILTER_EN
        u_d = {avg2(u_of(r[0], g[0], b[0]), u_of(r[1], g[1], b[1])),
               avg2(u_of(r[2], g[2], b[2]), u_of(r[3], g[3], b[3]))};
        v_d = {avg2(v_of(r[0], g[0], b[0]), v_of(r[1], g[1], b[1])),
               avg2(v_of(r[2], g[2], b[2]), v_of(r[3], g[3], b[3]))};
`else
        u_d = {u_of(r[0], g[0], b[0]), u_of(r[2], g[2], b[2])};
        v_d = {v_of(r[0], g[0], b[0]), v_of(r[2], g[2], b[2])};
`endif
    end

    // Reads for group g+1 are issued in group g's slots 0-5, so results are latched at the
    // group boundary (or slot 2 of a row's first group, after the lead-in data lands).
    always_comb begin
        state_d           = state_q;
        slot_d            = slot_q;
        x_d               = x_q;
        y_d               = y_q;
        done_d            = done_q;
        rgb_ptr_d         = rgb_ptr_q;
        y_ptr_d           = y_ptr_q;
        u_ptr_d           = u_ptr_q;
        v_ptr_d           = v_ptr_q;
        rd_issue          = 1'b0;
        conv              = 1'b0;
        SRAM_address_o    = 18'd0;
        SRAM_write_data_o = 16'd0;
        SRAM_we_n_o       = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (CSD_en) begin
                    done_d    = 1'b0;
                    rgb_ptr_d = RGB_BASE_A;
                    y_ptr_d   = Y_BASE_A;
                    u_ptr_d   = U_BASE_A;
                    v_ptr_d   = V_BASE_A;
                    x_d       = 7'd0;
                    y_d       = 8'd0;
                    slot_d    = 4'd0;
                    state_d   = StLeadIn;
                end
            end
            StLeadIn: begin
                rd_issue       = 1'b1;
                SRAM_address_o = rgb_ptr_q;
                rgb_ptr_d      = rgb_ptr_q + 18'd1;
                if (slot_q == 4'd5) begin
                    slot_d  = 4'd0;
                    state_d = StRun;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            StRun: begin
                slot_d = slot_q + 4'd1;
                if (slot_q < 4'd6 && !last_x) begin
                    rd_issue       = 1'b1;
                    SRAM_address_o = rgb_ptr_q;
                    rgb_ptr_d      = rgb_ptr_q + 18'd1;
                end
                if (slot_q == 4'd2 && x_q == 7'd0) conv = 1'b1;
                case (slot_q)
                    4'd6: begin
                        SRAM_we_n_o       = 1'b0;
                        SRAM_address_o    = y_ptr_q;
                        SRAM_write_data_o = y01_q;
                    end
                    4'd7: begin
                        SRAM_we_n_o       = 1'b0;
                        SRAM_address_o    = y_ptr_q + 18'd1;
                        SRAM_write_data_o = y23_q;
                        y_ptr_d           = y_ptr_q + 18'd2;
                    end
                    4'd8: begin
                        SRAM_we_n_o       = 1'b0;
                        SRAM_address_o    = u_ptr_q;
                        SRAM_write_data_o = u_q;
                        u_ptr_d           = u_ptr_q + 18'd1;
                    end
                    4'd9: begin
                        SRAM_we_n_o       = 1'b0;
                        SRAM_address_o    = v_ptr_q;
                        SRAM_write_data_o = v_q;
                        v_ptr_d           = v_ptr_q + 18'd1;
                        slot_d            = 4'd0;
                        if (last_x) begin
                            state_d = StLeadOut;
                        end else begin
                            x_d  = x_q + 7'd1;
                            conv = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            StLeadOut: begin
                x_d    = 7'd0;
                slot_d = 4'd0;
                if (y_q < LAST_Y) begin
                    y_d     = y_q + 8'd1;
                    state_d = StLeadIn;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            slot_q    <= 4'd0;
            x_q       <= 7'd0;
            y_q       <= 8'd0;
            done_q    <= 1'b0;
            rgb_ptr_q <= RGB_BASE_A;
            y_ptr_q   <= Y_BASE_A;
            u_ptr_q   <= U_BASE_A;
            v_ptr_q   <= V_BASE_A;
            tag_a_q   <= 4'd0;
            tag_b_q   <= 4'd0;
            for (int i = 0; i < 6; i++) w_q[i] <= 16'd0;
            y01_q     <= 16'd0;
            y23_q     <= 16'd0;
            u_q       <= 16'd0;
            v_q       <= 16'd0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            done_q    <= done_d;
            rgb_ptr_q <= rgb_ptr_d;
            y_ptr_q   <= y_ptr_d;
            u_ptr_q   <= u_ptr_d;
            v_ptr_q   <= v_ptr_d;
            // Two-stage tag follows each read to the cycle its data is on the bus.
            tag_a_q   <= {rd_issue, slot_q[2:0]};
            tag_b_q   <= tag_a_q;
            if (tag_b_q[3]) begin
                for (int i = 0; i < 6; i++) begin
                    if (tag_b_q[2:0] == 3'(i)) w_q[i] <= SRAM_read_data;
                end
            end
            if (conv) begin
                y01_q <= y01_d;
                y23_q <= y23_d;
                u_q   <= u_d;
                v_q   <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_decimation.sv
// Scoreboard bench for rgb_to_yuv_decimation on a reduced 16x6 frame with a 2-cycle SRAM model.
module tb_rgb_to_yuv_decimation;

    localparam int unsigned W      = 16;
    localparam int unsigned H      = 6;
    localparam int unsigned YB     = 0;
    localparam int unsigned UB     = 48;
    localparam int unsigned VB     = 72;
    localparam int unsigned RB     = 1000;
    localparam int unsigned G      = W / 4;
    localparam int unsigned NWORDS = W * H * 3 / 2;
    localparam int unsigned BOUND  = H * (G * 10 + 8) + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        csd_en;
    logic [15:0] sram_rd = 16'd0;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        we_n;
    logic        done;
    logic [6:0]  csd_x;
    logic [7:0]  csd_y;

    always #5 clk = ~clk;

    rgb_to_yuv_decimation #(
        .WIDTH(W), .HEIGHT(H), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .CSD_en(csd_en),
        .SRAM_read_data(sram_rd),
        .SRAM_address_o(addr),
        .SRAM_write_data_o(wdata),
        .SRAM_we_n_o(we_n),
        .done(done),
        .CSD_x(csd_x),
        .CSD_y(csd_y)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rgb [NWORDS];
    logic [33:0] exp_q [$];
    logic [15:0] p0 = 16'd0, p1 = 16'd0;
    int          wr_cnt = 0, wr_base = 0, done_rise = 0, done_base = 0;
    logic        done_prev = 1'b0;
    logic [15:0] first_wr [4];
    logic [17:0] first_wr_addr = 18'd0, last_y_addr = 18'd0, last_v_addr = 18'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int m_y(input int r, input int g, input int b);
        return clip((16843 * r + 33030 * g + 6423 * b + 1048576 + 32768) >>> 16);
    endfunction

    function automatic int m_u(input int r, input int g, input int b);
        return clip((-9699 * r - 19071 * g + 28770 * b + 8388608 + 32768) >>> 16);
    endfunction

    function automatic int m_v(input int r, input int g, input int b);
        return clip((28770 * r - 24117 * g - 4653 * b + 8388608 + 32768) >>> 16);
    endfunction

    function automatic logic [15:0] rd_word(input logic [17:0] a);
        if (a >= 18'(RB) && a < 18'(RB + NWORDS)) return rgb[int'(a) - RB];
        return 16'hDEAD;
    endfunction

    // SRAM model: data for the address seen in cycle c is presented in cycle c+2.
    always @(posedge clk) begin
        logic [33:0] e;
        #1;
        sram_rd = p1;
        p1 = p0;
        p0 = rd_word(addr);
        if (!we_n) begin
            if (wr_cnt == wr_base) first_wr_addr = addr;
            if (wr_cnt - wr_base < 4) first_wr[wr_cnt - wr_base] = wdata;
            if (addr < 18'(UB)) last_y_addr = addr;
            if (addr >= 18'(VB) && addr < 18'(VB + W * H / 4)) last_v_addr = addr;
            wr_cnt++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {18'h3FFFF, 16'hFFFF};
            check_eq("wr_addr", 32'(addr), 32'(e[33:16]));
            check_eq("wr_data", 32'(wdata), 32'(e[15:0]));
        end
        if (done && !done_prev) done_rise++;
        done_prev = done;
    end

    task automatic fill(input int mode);
        logic [15:0] red_w [6];
        red_w = '{16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000};
        for (int i = 0; i < NWORDS; i++) begin
            case (mode)
                0: rgb[i] = 16'h0000;
                1: rgb[i] = 16'hFFFF;
                2: rgb[i] = (i < 6) ? red_w[i] : 16'($urandom);
                3: rgb[i] = (i == 0) ? 16'hFF00 : 16'h0000;
                default: rgb[i] = 16'($urandom);
            endcase
        end
    endtask

    task automatic build_expect();
        int pr [4], pg [4], pb [4], yv [4], uv [4], vv [4];
        int gi, uo, vo;
        logic [15:0] wd [6];
        for (int row = 0; row < H; row++) begin
            for (int grp = 0; grp < G; grp++) begin
                gi = row * G + grp;
                for (int k = 0; k < 6; k++) wd[k] = rgb[gi * 6 + k];
                for (int p = 0; p < 2; p++) begin
                    pr[2*p]   = wd[3*p][15:8];
                    pg[2*p]   = wd[3*p][7:0];
                    pb[2*p]   = wd[3*p+1][15:8];
                    pr[2*p+1] = wd[3*p+1][7:0];
                    pg[2*p+1] = wd[3*p+2][15:8];
                    pb[2*p+1] = wd[3*p+2][7:0];
                end
                for (int p = 0; p < 4; p++) begin
                    yv[p] = m_y(pr[p], pg[p], pb[p]);
                    uv[p] = m_u(pr[p], pg[p], pb[p]);
                    vv[p] = m_v(pr[p], pg[p], pb[p]);
                end
                exp_q.push_back({18'(YB + gi * 2), 8'(yv[0]), 8'(yv[1])});
                exp_q.push_back({18'(YB + gi * 2 + 1), 8'(yv[2]), 8'(yv[3])});
`ifdef CSD_CHROMA_FILTER_EN
                uo = (((uv[0] + uv[1] + 1) >> 1) << 8) | ((uv[2] + uv[3] + 1) >> 1);
                vo = (((vv[0] + vv[1] + 1) >> 1) << 8) | ((vv[2] + vv[3] + 1) >> 1);
`else
                uo = (uv[0] << 8) | uv[2];
                vo = (vv[0] << 8) | vv[2];
`endif
                exp_q.push_back({18'(UB + gi), 16'(uo)});
                exp_q.push_back({18'(VB + gi), 16'(vo)});
            end
        end
    endtask

    task automatic start_frame(input int mode);
        fill(mode);
        build_expect();
        wr_base   = wr_cnt;
        done_base = done_rise;
        @(negedge clk) csd_en = 1'b1;
        @(negedge clk) csd_en = 1'b0;
        check_eq("first_rd_addr", 32'(addr), 32'(RB));
    endtask

    task automatic finish_frame(input bit poke);
        int cyc = 0;
        while (!done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 60) csd_en = 1'b1;
            if (poke && cyc == 61) csd_en = 1'b0;
        end
        check_eq("frame_done_in_bound", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("wr_count", 32'(wr_cnt - wr_base), 32'(W * H));
        check_eq("done_rises", 32'(done_rise - done_base), 32'd1);
    endtask

    initial begin
        int cyc;
        int low;
        rst    = 1'b1;
        csd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_we_n", 32'(we_n), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_x", 32'(csd_x), 32'd0);
        check_eq("rst_y", 32'(csd_y), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_frame(0);
        finish_frame(1'b0);
        check_eq("black_y", 32'(first_wr[0]), 32'h1010);
        check_eq("black_u", 32'(first_wr[2]), 32'h8080);
        check_eq("black_v", 32'(first_wr[3]), 32'h8080);

        start_frame(1);
        finish_frame(1'b0);
        check_eq("white_y", 32'(first_wr[0]), 32'hEBEB);
        check_eq("white_u", 32'(first_wr[2]), 32'h8080);
        check_eq("last_y_addr", 32'(last_y_addr), 32'(YB + W * H / 2 - 1));
        check_eq("last_v_addr", 32'(last_v_addr), 32'(VB + W * H / 4 - 1));

        start_frame(2);
        finish_frame(1'b0);
        check_eq("red_y01", 32'(first_wr[0]), 32'h5252);
        check_eq("red_y23", 32'(first_wr[1]), 32'h5252);
        check_eq("red_u", 32'(first_wr[2]), 32'h5A5A);
        check_eq("red_v", 32'(first_wr[3]), 32'hF0F0);

        start_frame(3);
        finish_frame(1'b0);
`ifdef CSD_CHROMA_FILTER_EN
        check_eq("pix0_u_hi", 32'(first_wr[2][15:8]), 32'h6D);
        check_eq("pix0_v_hi", 32'(first_wr[3][15:8]), 32'hB8);
`else
        check_eq("pix0_u_hi", 32'(first_wr[2][15:8]), 32'h5A);
        check_eq("pix0_v_hi", 32'(first_wr[3][15:8]), 32'hF0);
`endif

        start_frame(4);
        finish_frame(1'b1);

        // Abort mid-frame with a one-cycle reset, then restart cleanly.
        start_frame(4);
        cyc = 0;
        while (csd_y != 8'd2 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reached_row2", 32'(csd_y), 32'd2);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_eq("abort_we_n", 32'(we_n), 32'd1);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_x", 32'(csd_x), 32'd0);
        check_eq("abort_y", 32'(csd_y), 32'd0);
        exp_q.delete();
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (!we_n) low++;
        end
        check_eq("abort_no_writes", 32'(low), 32'd0);
        check_eq("abort_done_idle", 32'(done), 32'd0);
        start_frame(4);
        finish_frame(1'b0);
        check_eq("restart_first_wr", 32'(first_wr_addr), 32'(YB));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
